morse_element_classifier: RTL and testbench

//  Parametrised successor to the dit/dah decoder. Classifies a keyed Morse input into
//  DIT, DAH, GAP, SPACE and ERR symbols. Decisions use run-time unit-relative thresholds

---
 rtl/morse_element_classifier.sv | 171 +++++++++++++++++
 tb/tb_morse_element_classifier.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_element_classifier.sv
// Morse element classifier: synchronised key level -> DIT/DAH/GAP/SPACE/ERR strobes.
// Optional glitch filter on the level path enabled by defining MORSE_DEBOUNCE_EN.
module morse_element_classifier #(
    parameter int CNT_WIDTH  = 27,
    parameter int MAX_ELEMS  = 6,
    parameter int DEB_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 signal,
    input  logic [CNT_WIDTH-1:0] unit_cycles,
    output logic [2:0]           sym_code,
    output logic                 sym_valid,
    output logic [3:0]           elem_count,
    output logic                 busy
);

    localparam int TW = CNT_WIDTH + 3;

    typedef enum logic [1:0] {S_IDLE, S_MARK, S_ISPACE, S_LSPACE} state_t;
    typedef enum logic [2:0] {
        SYM_NONE  = 3'd0,
        SYM_DIT   = 3'd1,
        SYM_DAH   = 3'd2,
        SYM_GAP   = 3'd3,
        SYM_SPACE = 3'd4,
        SYM_ERR   = 3'd5
    } sym_t;

    state_t                 r_state, w_next;
    sym_t                   w_sym;
    logic                   r_sync1, r_sync2, r_vld1, r_vld2, r_armed, r_prev;
    logic                   w_lvl, w_edge, w_sat;
    logic [CNT_WIDTH-1:0]   r_cnt, r_unit, w_unit_in;
    logic [TW-1:0]          w_u, w_run, w_h, w_t2, w_t3, w_t5, w_t7;
    logic [2:0]             r_sym_code;
    logic                   r_sym_valid;
    logic [3:0]             r_elem_count, w_elem_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_vld1  <= 1'b0;
            r_vld2  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= signal;
            r_sync2 <= r_sync1;
            r_vld1  <= 1'b1;
            r_vld2  <= r_vld1;
            // A mark already in progress at reset is discarded: marks are only
            // accepted once a genuine (post-reset) low sample has been seen.
            r_armed <= r_armed | (r_vld2 & ~r_sync2);
        end
    end

`ifdef MORSE_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);
    logic          r_lvl;
    logic [DW-1:0] r_deb_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lvl     <= 1'b0;
            r_deb_cnt <= '0;
        end else if (r_sync2 == r_lvl) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == DW'(DEB_CYCLES - 1)) begin
            r_lvl     <= ~r_lvl;
            r_deb_cnt <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + DW'(1);
        end
    end
    assign w_lvl = r_lvl;
`else
    logic w_unused_deb;
    assign w_unused_deb = (DEB_CYCLES != 0);
    assign w_lvl        = r_sync2;
`endif

    assign w_edge    = w_lvl ^ r_prev;
    assign w_sat     = (r_cnt == '1);
    assign w_unit_in = (unit_cycles == '0) ? CNT_WIDTH'(1) : unit_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_prev <= w_lvl;
            if (w_edge)      r_cnt <= CNT_WIDTH'(1);
            else if (!w_sat) r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || r_state == S_IDLE) r_unit <= w_unit_in;
    end

    assign w_u   = TW'(r_unit);
    assign w_run = TW'(r_cnt);
    assign w_h   = w_u >> 1;
    assign w_t2  = w_u << 1;
    assign w_t3  = w_u * TW'(3);
    assign w_t5  = w_u * TW'(5);
    assign w_t7  = w_u * TW'(7);

    always_comb begin
        w_next      = r_state;
        w_sym       = SYM_NONE;
        w_elem_next = r_elem_count;
        case (r_state)
            S_IDLE: begin
                if (w_edge && w_lvl && r_armed) w_next = S_MARK;
            end
            S_MARK: begin
                if (w_edge) begin
                    if (w_sat || w_run < w_h || w_run >= w_t5) begin
                        w_sym = SYM_ERR;
                    end else if (r_elem_count == 4'(MAX_ELEMS)) begin
                        w_sym = SYM_ERR;
                    end else begin
                        w_sym       = (w_run < w_t2) ? SYM_DIT : SYM_DAH;
                        w_elem_next = r_elem_count + 4'd1;
                    end
                    w_next = S_ISPACE;
                end
            end
            S_ISPACE: begin
                if (w_edge) begin
                    w_next = S_MARK;
                end else if (w_run == w_t3) begin
                    w_sym       = SYM_GAP;
                    w_elem_next = '0;
                    w_next      = S_LSPACE;
                end
            end
            S_LSPACE: begin
                if (w_edge) begin
                    w_next = S_MARK;
                end else if (w_run == w_t7) begin
                    w_sym  = SYM_SPACE;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sym_code   <= '0;
            r_sym_valid  <= 1'b0;
            r_elem_count <= '0;
        end else begin
            r_state      <= w_next;
            r_sym_code   <= w_sym;
            r_sym_valid  <= (w_sym != SYM_NONE);
            r_elem_count <= w_elem_next;
        end
    end

    assign sym_code   = r_sym_code;
    assign sym_valid  = r_sym_valid;
    assign elem_count = r_elem_count;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_morse_element_classifier.sv
// Directed bench for morse_element_classifier with unit_cycles=10 (H=5, T2=20, T3=30, T5=50, T7=70).
// A negedge monitor logs every strobed symbol; each test task checks the log inline.
module tb_morse_element_classifier;

    localparam int CW = 27;
    localparam int C_DIT = 1, C_DAH = 2, C_GAP = 3, C_SPACE = 4, C_ERR = 5;

    logic          clk = 1'b0;
    logic          reset, signal;
    logic [CW-1:0] unit_cycles;
    logic [2:0]    sym_code;
    logic          sym_valid;
    logic [3:0]    elem_count;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    logic [2:0] q_code[$];
    logic [3:0] q_elem[$];
    int         q_cyc[$];

    morse_element_classifier #(
        .CNT_WIDTH (CW),
        .MAX_ELEMS (6),
        .DEB_CYCLES(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .signal     (signal),
        .unit_cycles(unit_cycles),
        .sym_code   (sym_code),
        .sym_valid  (sym_valid),
        .elem_count (elem_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (sym_valid) begin
            q_code.push_back(sym_code);
            q_elem.push_back(elem_count);
            q_cyc.push_back(cycle);
        end
    end

    task automatic drive(input logic lvl, input int n);
        signal = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        q_code.delete();
        q_elem.delete();
        q_cyc.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        signal = 1'b0;
        unit_cycles = CW'(10);
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (sym_code !== 3'd0)   begin bad++; $display("FAIL reset_code got=%0d exp=0", sym_code); end
        total++; if (sym_valid !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%0b exp=0", sym_valid); end
        total++; if (elem_count !== 4'd0) begin bad++; $display("FAIL reset_elem got=%0d exp=0", elem_count); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b0, 5);
    endtask

    task automatic test_dit_gap_space();
        int ec[$];
        int ee[$];
        ec = '{C_DIT, C_GAP, C_SPACE};
        ee = '{1, 0, 0};
        clear_log();
        drive(1'b1, 10);
        drive(1'b0, 80);
        total++; if (q_code.size() !== ec.size()) begin bad++; $display("FAIL dgs_count got=%0d exp=%0d", q_code.size(), ec.size()); end
        for (int i = 0; i < ec.size() && i < q_code.size(); i++) begin
            total++;
            if (q_code[i] !== ec[i] || q_elem[i] !== ee[i]) begin
                bad++; $display("FAIL dgs_sym[%0d] got code=%0d elem=%0d exp code=%0d elem=%0d", i, q_code[i], q_elem[i], ec[i], ee[i]);
            end
        end
        if (q_cyc.size() == 3) begin
            total++; if (q_cyc[1] - q_cyc[0] !== 30) begin bad++; $display("FAIL gap_latency got=%0d exp=30", q_cyc[1] - q_cyc[0]); end
            total++; if (q_cyc[2] - q_cyc[1] !== 40) begin bad++; $display("FAIL space_latency got=%0d exp=40", q_cyc[2] - q_cyc[1]); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL dgs_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_dah_dit();
        int ec[$];
        int ee[$];
        ec = '{C_DAH, C_DAH, C_DIT, C_GAP, C_SPACE};
        ee = '{1, 2, 3, 0, 0};
        clear_log();
        drive(1'b1, 30); drive(1'b0, 10);
        drive(1'b1, 25); drive(1'b0, 10);
        drive(1'b1, 19); drive(1'b0, 80);
        total++; if (q_code.size() !== ec.size()) begin bad++; $display("FAIL dahdit_count got=%0d exp=%0d", q_code.size(), ec.size()); end
        for (int i = 0; i < ec.size() && i < q_code.size(); i++) begin
            total++;
            if (q_code[i] !== ec[i] || q_elem[i] !== ee[i]) begin
                bad++; $display("FAIL dahdit_sym[%0d] got code=%0d elem=%0d exp code=%0d elem=%0d", i, q_code[i], q_elem[i], ec[i], ee[i]);
            end
        end
    endtask

    task automatic test_thresholds();
        int ec[$];
        int ee[$];
        ec = '{C_DIT, C_DAH, C_DAH, C_GAP, C_SPACE};
        ee = '{1, 2, 3, 0, 0};
        clear_log();
        drive(1'b1, 5);  drive(1'b0, 10);
        drive(1'b1, 20); drive(1'b0, 10);
        drive(1'b1, 49); drive(1'b0, 80);
        total++; if (q_code.size() !== ec.size()) begin bad++; $display("FAIL thresh_count got=%0d exp=%0d", q_code.size(), ec.size()); end
        for (int i = 0; i < ec.size() && i < q_code.size(); i++) begin
            total++;
            if (q_code[i] !== ec[i] || q_elem[i] !== ee[i]) begin
                bad++; $display("FAIL thresh_sym[%0d] got code=%0d elem=%0d exp code=%0d elem=%0d", i, q_code[i], q_elem[i], ec[i], ee[i]);
            end
        end
    endtask

    task automatic test_err();
        int ec[$];
        int ee[$];
        ec = '{C_DIT, C_ERR, C_ERR, C_GAP, C_SPACE};
        ee = '{1, 1, 1, 0, 0};
        clear_log();
        drive(1'b1, 10); drive(1'b0, 10);
        drive(1'b1, 4);  drive(1'b0, 10);
        drive(1'b1, 50); drive(1'b0, 80);
        total++; if (q_code.size() !== ec.size()) begin bad++; $display("FAIL err_count got=%0d exp=%0d", q_code.size(), ec.size()); end
        for (int i = 0; i < ec.size() && i < q_code.size(); i++) begin
            total++;
            if (q_code[i] !== ec[i] || q_elem[i] !== ee[i]) begin
                bad++; $display("FAIL err_sym[%0d] got code=%0d elem=%0d exp code=%0d elem=%0d", i, q_code[i], q_elem[i], ec[i], ee[i]);
            end
        end
    endtask

    task automatic test_gap_edge();
        int ec[$];
        int ee[$];
        ec = '{C_DIT, C_DIT, C_GAP, C_DIT, C_GAP, C_SPACE};
        ee = '{1, 2, 0, 1, 0, 0};
        clear_log();
        drive(1'b1, 10); drive(1'b0, 30);
        drive(1'b1, 10); drive(1'b0, 31);
        drive(1'b1, 10); drive(1'b0, 80);
        total++; if (q_code.size() !== ec.size()) begin bad++; $display("FAIL gapedge_count got=%0d exp=%0d", q_code.size(), ec.size()); end
        for (int i = 0; i < ec.size() && i < q_code.size(); i++) begin
            total++;
            if (q_code[i] !== ec[i] || q_elem[i] !== ee[i]) begin
                bad++; $display("FAIL gapedge_sym[%0d] got code=%0d elem=%0d exp code=%0d elem=%0d", i, q_code[i], q_elem[i], ec[i], ee[i]);
            end
        end
    endtask

    task automatic test_max_elems();
        int ec[$];
        int ee[$];
        ec = '{C_DIT, C_DIT, C_DIT, C_DIT, C_DIT, C_DIT, C_ERR, C_GAP, C_SPACE};
        ee = '{1, 2, 3, 4, 5, 6, 6, 0, 0};
        clear_log();
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 10);
            drive(1'b0, 10);
        end
        total++; if (elem_count !== 4'd6) begin bad++; $display("FAIL max_hold got=%0d exp=6", elem_count); end
        drive(1'b0, 80);
        total++; if (q_code.size() !== ec.size()) begin bad++; $display("FAIL max_count got=%0d exp=%0d", q_code.size(), ec.size()); end
        for (int i = 0; i < ec.size() && i < q_code.size(); i++) begin
            total++;
            if (q_code[i] !== ec[i] || q_elem[i] !== ee[i]) begin
                bad++; $display("FAIL max_sym[%0d] got code=%0d elem=%0d exp code=%0d elem=%0d", i, q_code[i], q_elem[i], ec[i], ee[i]);
            end
        end
    endtask

    task automatic test_reset_mid_mark();
        int ec[$];
        int ee[$];
        ec = '{C_DIT, C_GAP, C_SPACE};
        ee = '{1, 0, 0};
        drive(1'b1, 10); drive(1'b0, 10);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmm_busy_before got=%0b exp=1", busy); end
        drive(1'b1, 5);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if (sym_code !== 3'd0)   begin bad++; $display("FAIL rmm_code got=%0d exp=0", sym_code); end
        total++; if (sym_valid !== 1'b0)  begin bad++; $display("FAIL rmm_valid got=%0b exp=0", sym_valid); end
        total++; if (elem_count !== 4'd0) begin bad++; $display("FAIL rmm_elem got=%0d exp=0", elem_count); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rmm_busy got=%0b exp=0", busy); end
        clear_log();
        drive(1'b1, 24);
        drive(1'b0, 80);
        total++; if (q_code.size() !== 0) begin bad++; $display("FAIL rmm_discard got=%0d symbols exp=0", q_code.size()); end
        drive(1'b1, 10);
        drive(1'b0, 80);
        total++; if (q_code.size() !== ec.size()) begin bad++; $display("FAIL rmm_recover_count got=%0d exp=%0d", q_code.size(), ec.size()); end
        for (int i = 0; i < ec.size() && i < q_code.size(); i++) begin
            total++;
            if (q_code[i] !== ec[i] || q_elem[i] !== ee[i]) begin
                bad++; $display("FAIL rmm_sym[%0d] got code=%0d elem=%0d exp code=%0d elem=%0d", i, q_code[i], q_elem[i], ec[i], ee[i]);
            end
        end
    endtask

`ifdef MORSE_DEBOUNCE_EN
    task automatic test_debounce();
        int ec[$];
        int ee[$];
        ec = '{C_DAH, C_GAP, C_SPACE};
        ee = '{1, 0, 0};
        clear_log();
        drive(1'b1, 13); drive(1'b0, 3); drive(1'b1, 14);
        drive(1'b0, 80);
        drive(1'b1, 3);
        drive(1'b0, 80);
        total++; if (q_code.size() !== ec.size()) begin bad++; $display("FAIL deb_count got=%0d exp=%0d", q_code.size(), ec.size()); end
        for (int i = 0; i < ec.size() && i < q_code.size(); i++) begin
            total++;
            if (q_code[i] !== ec[i] || q_elem[i] !== ee[i]) begin
                bad++; $display("FAIL deb_sym[%0d] got code=%0d elem=%0d exp code=%0d elem=%0d", i, q_code[i], q_elem[i], ec[i], ee[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_dit_gap_space();
        test_dah_dit();
        test_thresholds();
        test_err();
        test_gap_edge();
        test_max_elems();
        test_reset_mid_mark();
`ifdef MORSE_DEBOUNCE_EN
        test_debounce();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
